spiflash_read_ctrl: RTL and testbench
=====================================

// Module: spiflash_read_ctrl
// PURPOSE
//   Single-bit SPI flash read initiator for the management SoC boot/fetch path;
//   it drives the same flash_csb/flash_clk/io0/io1 pins that the spiflash model answers.
//   After reset it issues release-from-power-down (0xAB). It then serves 32-bit word
//   reads as READ (0x03) + 24-bit address + 32 data bits, MSB-first, SPI mode 0.
// PARAMETERS
//   CLK_DIV   2   core_clk cycles per flash_clk half-period (>=1)
//   CSB_HIGH  4   minimum core_clk cycles flash_csb is held high between transactions
//   WAKE_OP   8'hAB  opcode sent once after reset
//   READ_OP   8'h03  read opcode
// PORTS
//   core_clk       in   1   system clock
//   core_rstn      in   1   reset, asynchronous, active-low
//   req_valid      in   1   read request
//   req_addr       in   24  byte address of the first byte returned
//   req_ready      out  1   controller idle; request accepted when req_valid&req_ready
//   rsp_valid      out  1   one-cycle pulse: rsp_data valid
//   rsp_data       out  32  byte at addr in [7:0], addr+1 in [15:8], ... (little-endian)
//   flash_csb      out  1   chip select, active-low
//   flash_clk      out  1   SPI clock, idles low
//   flash_io0_do   out  1   MOSI
//   flash_io0_oeb  out  1   constant 0 (io0 always driven)
//   flash_io1_oeb  out  1   constant 1 (io1 always input)
//   flash_io1_di   in   1   MISO
// BEHAVIOUR
//   Reset values: req_ready=0, rsp_valid=0, rsp_data=0, flash_csb=1, flash_clk=0, io0_do=0.
//   FSM: WAKE -> WAKE_GAP -> IDLE -> SHIFT -> GAP -> IDLE.
//   - WAKE: first cycle after reset release, csb=0; 8 SCK cycles shift WAKE_OP.
//     Then WAKE_GAP: csb=1 for CSB_HIGH cycles, then IDLE.
//   - IDLE: req_ready=1. Accepting at cycle T latches the address and moves to SHIFT.
//   - SHIFT: at T+1, csb=0 and io0 = bit 7 of READ_OP. Shift 64 bits: 8 opcode, 24 addr, 32 data.
//     The k-th rising flash_clk edge (k=0..63) falls at T+1+CLK_DIV+2*k*CLK_DIV.
//     io0 changes only on falling edges (or at csb fall for bit 0).
//     io1 is sampled on rising edges k=32..63.
//     After the last rising edge, flash_clk returns low; io0 is don't-care, driven 0 in data phase.
//   - At T+2+127*CLK_DIV: rsp_valid=1 for exactly one cycle, rsp_data updated,
//     csb=1, clk=0, enter GAP. Default CLK_DIV=2 gives T+256.
//   - GAP: csb=1 for CSB_HIGH cycles; req_ready=0 throughout; then IDLE.
//   Bytes arrive MSB-first and are byte-swapped into rsp_data per the PORTS mapping.
//   rsp_data holds its value until the next response.
//   Boundaries:
//   - req_valid while req_ready=0 is ignored; the requester must hold it.
//   - Unaligned addresses are legal, sent verbatim.
//   - Address 24'hFFFFFE etc. is sent as-is; wrap is the flash's concern.
//   - Asserting core_rstn low mid-transaction forces csb=1/clk=0 immediately (async).
//     No rsp_valid is issued, and the wake sequence reruns on release.
//   - Back-to-back requests are spaced by at least CSB_HIGH+1 cycles of csb high.
// STRUCTURE
//   Package flash_ctrl_pkg: opcode constants, state enum, phase bit counts (8/24/32).
//   Sub-module spi_sck_gen: CLK_DIV counter producing flash_clk plus
//   one-cycle rise/fall strobes. The top holds the FSM, the 64-bit shift-out
//   register and the 32-bit shift-in register.
// TESTING
//   1. Reset release, CLK_DIV=2 -> csb low for 8 SCK; MOSI 1010_1011;
//      csb high 4 cycles; req_ready=1.
//   2. Read addr 24'h000010 from a spiflash holding 6F,00,00,0B ->
//      MOSI 03_000010; rsp_data=32'h0B00006F at T+256.
//   3. req_valid held high across two requests -> second csb fall no earlier than
//      CSB_HIGH+1 cycles after the first csb rise; req_ready=0 in between.
//   4. Pull core_rstn low at SCK edge 40 -> csb=1 the same timestep, no rsp_valid;
//      on release, the wake sequence repeats.
//   5. CLK_DIV=1, addr 24'hFFFFFF -> SCK = core_clk/2; response at T+129;
//      address bits all ones on MOSI.
//   6. Protocol checker on every read: io0 stable on rising edges,
//      exactly 64 rising edges per csb-low window, rsp_valid width = 1 cycle.

Source files
------------

// File: rtl/flash_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the SPI flash read controller.
package flash_ctrl_pkg;

    localparam logic [7:0] OPC_WAKE = 8'hAB;
    localparam logic [7:0] OPC_READ = 8'h03;

    localparam int OP_BITS   = 8;
    localparam int ADDR_BITS = 24;
    localparam int DATA_BITS = 32;

    typedef enum logic [2:0] {
        ST_WAKE,
        ST_WAKE_GAP,
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    // Flash returns the lowest-addressed byte first; it belongs in bits [7:0].
    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock divider: flash_clk toggles every CLK_DIV core cycles while enabled,
// with one-cycle strobes flagging the edge that the next core edge will produce.
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_sck;
    logic          w_tick;

    assign w_tick = i_en && (r_cnt == CW'(CLK_DIV - 1));
    assign o_rise = w_tick && !r_sck;
    assign o_fall = w_tick && r_sck;
    assign o_sck  = r_sck;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_sck <= !r_sck;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spiflash_read_ctrl.sv
// Single-bit SPI flash read initiator: wakes the flash after reset, then serves
// 32-bit little-endian word reads with READ + 24-bit address, SPI mode 0.
module spiflash_read_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int         CLK_DIV  = 2,
    parameter int         CSB_HIGH = 4,
    parameter logic [7:0] WAKE_OP  = OPC_WAKE,
    parameter logic [7:0] READ_OP  = OPC_READ
) (
    input  logic        core_clk,
    input  logic        core_rstn,
    input  logic        req_valid,
    input  logic [23:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0_do,
    output logic        flash_io0_oeb,
    output logic        flash_io1_oeb,
    input  logic        flash_io1_di
);

    localparam logic [7:0] GAP_LOAD   = 8'(CSB_HIGH - 1);
    localparam logic [6:0] WAKE_RISES = 7'(OP_BITS);
    localparam logic [6:0] READ_RISES = 7'(OP_BITS + ADDR_BITS + DATA_BITS);
    localparam logic [6:0] DATA_START = 7'(OP_BITS + ADDR_BITS);

    state_t      r_state;
    logic        r_csb;
    logic        r_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic [63:0] r_sout;
    logic [31:0] r_sin;
    logic [6:0]  r_nrise;
    logic [7:0]  r_gap;

    logic        w_sck;
    logic        w_rise;
    logic        w_fall;
    logic        w_sck_en;
    logic [6:0]  w_target;

    assign w_target = (r_state == ST_SHIFT) ? READ_RISES : WAKE_RISES;
    // The clock stops (and is forced low) as soon as the last rising edge has been issued.
    assign w_sck_en = ((r_state == ST_WAKE) || (r_state == ST_SHIFT)) && !r_csb &&
                      (r_nrise != w_target);

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .i_clk  (core_clk),
        .i_rst_n(core_rstn),
        .i_en   (w_sck_en),
        .o_sck  (w_sck),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            r_state     <= ST_WAKE;
            r_csb       <= 1'b1;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_sout      <= '0;
            r_sin       <= '0;
            r_nrise     <= '0;
            r_gap       <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_fall) begin
                r_sout <= {r_sout[62:0], 1'b0};
            end
            if (w_rise) begin
                r_nrise <= r_nrise + 7'd1;
                if ((r_state == ST_SHIFT) && (r_nrise >= DATA_START)) begin
                    r_sin <= {r_sin[30:0], flash_io1_di};
                end
            end
            case (r_state)
                ST_WAKE: begin
                    if (r_csb) begin
                        r_csb   <= 1'b0;
                        r_sout  <= {WAKE_OP, 56'b0};
                        r_nrise <= '0;
                    end else if (r_nrise == WAKE_RISES) begin
                        r_csb   <= 1'b1;
                        r_sout  <= '0;
                        r_gap   <= GAP_LOAD;
                        r_state <= ST_WAKE_GAP;
                    end
                end
                ST_WAKE_GAP, ST_GAP: begin
                    if (r_gap == 8'd0) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_gap <= r_gap - 8'd1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        r_ready <= 1'b0;
                        r_csb   <= 1'b0;
                        r_sout  <= {READ_OP, req_addr, 32'b0};
                        r_nrise <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_nrise == READ_RISES) begin
                        r_csb       <= 1'b1;
                        r_sout      <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= bswap32(r_sin);
                        r_gap       <= GAP_LOAD;
                        r_state     <= ST_GAP;
                    end
                end
                default: begin
                    r_state <= ST_WAKE;
                    r_csb   <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready     = r_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign flash_csb     = r_csb;
    assign flash_clk     = w_sck;
    assign flash_io0_do  = r_sout[63];
    assign flash_io0_oeb = 1'b0;
    assign flash_io1_oeb = 1'b1;

endmodule

// File: tb/tb_spiflash_read_ctrl.sv
// Bench for spiflash_read_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1) share one
// flash model and one scoreboard/protocol monitor through a select mux.
`timescale 1ns/1ps
module tb_spiflash_read_ctrl;

    logic core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    logic        rstn0, rstn1, req_valid0, req_valid1;
    logic [23:0] req_addr0, req_addr1;
    logic        ready0, ready1, rv0, rv1;
    logic [31:0] rd0, rd1;
    logic        csb0, csb1, sck0, sck1, io0_0, io0_1;
    logic        oeb0_0, oeb1_0, oeb0_1, oeb1_1;
    logic        io1_di = 1'b0;

    spiflash_read_ctrl #(.CLK_DIV(2), .CSB_HIGH(4)) u_dut0 (
        .core_clk(core_clk), .core_rstn(rstn0), .req_valid(req_valid0), .req_addr(req_addr0),
        .req_ready(ready0), .rsp_valid(rv0), .rsp_data(rd0), .flash_csb(csb0),
        .flash_clk(sck0), .flash_io0_do(io0_0), .flash_io0_oeb(oeb0_0),
        .flash_io1_oeb(oeb1_0), .flash_io1_di(io1_di));

    spiflash_read_ctrl #(.CLK_DIV(1), .CSB_HIGH(4)) u_dut1 (
        .core_clk(core_clk), .core_rstn(rstn1), .req_valid(req_valid1), .req_addr(req_addr1),
        .req_ready(ready1), .rsp_valid(rv1), .rsp_data(rd1), .flash_csb(csb1),
        .flash_clk(sck1), .flash_io0_do(io0_1), .flash_io0_oeb(oeb0_1),
        .flash_io1_oeb(oeb1_1), .flash_io1_di(io1_di));

    logic sel = 1'b0;
    int   clkdiv_sel = 2;
    logic m_csb, m_sck, m_io0, m_rstn, m_ready, m_rv, m_valid;
    logic [31:0] m_data;
    assign m_csb   = sel ? csb1   : csb0;
    assign m_sck   = sel ? sck1   : sck0;
    assign m_io0   = sel ? io0_1  : io0_0;
    assign m_rstn  = sel ? rstn1  : rstn0;
    assign m_ready = sel ? ready1 : ready0;
    assign m_rv    = sel ? rv1    : rv0;
    assign m_data  = sel ? rd1    : rd0;
    assign m_valid = sel ? req_valid1 : req_valid0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Flash memory image: a few fixed words, otherwise a simple address pattern.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000010: return 8'h6F;
            24'h000011: return 8'h00;
            24'h000012: return 8'h00;
            24'h000013: return 8'h0B;
            default:    return a[7:0] ^ a[23:16];
        endcase
    endfunction

    int          f_nrise = 0;
    logic [31:0] f_cmd = '0;

    always @(negedge m_csb) begin
        f_nrise = 0;
        f_cmd   = '0;
    end

    always @(posedge m_sck) begin
        if (!m_csb) begin
            if (f_nrise < 32) f_cmd = {f_cmd[30:0], m_io0};
            f_nrise++;
        end
    end

    always @(negedge m_sck) begin
        int          d;
        logic [23:0] a;
        logic [7:0]  b;
        if (!m_csb && f_nrise >= 32 && f_nrise < 64) begin
            d = f_nrise - 32;
            a = f_cmd[23:0] + 24'(d / 8);
            b = mem_byte(a);
            io1_di = b[7 - (d % 8)];
        end
    end

    logic [31:0] exp_q[$];
    logic [23:0] cmd_q[$];
    int          acc_q[$];
    int          cyc = 0;

    always @(posedge core_clk) begin
        cyc++;
        if (!m_rstn) acc_q.delete();
        else if (m_valid && m_ready) acc_q.push_back(cyc);
    end

    logic p_csb = 1'b1, p_sck = 1'b0, p_io0 = 1'b0, p_rv = 1'b0;
    int   rises = 0, hi_cnt = 0, hi_nordy = 0, wake_windows = 0;
    bit   in_wake = 1'b1, after_read = 1'b0, io0_bad = 1'b0, rdy_bad = 1'b0, wg_act = 1'b0;

    always @(negedge core_clk) begin
        if (!m_rstn) begin
            in_wake = 1'b1;
            after_read = 1'b0;
            wg_act = 1'b0;
            rises = 0;
            hi_cnt = 0;
        end else begin
            if (p_csb && !m_csb) begin
                if (after_read) begin
                    checks++;
                    if (hi_cnt < 5) begin
                        errors++;
                        $display("FAIL csb_gap: got %0d high cycles, expected at least 5", hi_cnt);
                    end
                end
                rises = 0;
                io0_bad = 1'b0;
                rdy_bad = 1'b0;
            end
            if (!m_csb) begin
                if (!p_sck && m_sck) begin
                    rises++;
                    if (m_io0 !== p_io0) io0_bad = 1'b1;
                end
                if (m_ready) rdy_bad = 1'b1;
            end
            if (!p_csb && m_csb) begin
                if (in_wake) begin
                    chk("wake_rises", 64'(rises), 64'd8);
                    chk("wake_op", 64'(f_cmd[7:0]), 64'hAB);
                    wake_windows++;
                    in_wake = 1'b0;
                    after_read = 1'b0;
                    wg_act = 1'b1;
                    hi_nordy = 0;
                end else begin
                    chk("read_rises", 64'(rises), 64'd64);
                    if (cmd_q.size() == 0) fail_now("read_cmd_unexpected");
                    else chk("read_cmd", 64'(f_cmd), 64'({8'h03, cmd_q.pop_front()}));
                    after_read = 1'b1;
                end
                chk("io0_stable_at_rise", 64'(io0_bad), 64'd0);
                chk("ready_low_in_xfer", 64'(rdy_bad), 64'd0);
                hi_cnt = 0;
            end
            if (m_csb) hi_cnt++;
            if (wg_act) begin
                if (m_ready) begin
                    chk("wake_gap_len", 64'(hi_nordy), 64'd4);
                    wg_act = 1'b0;
                end else begin
                    hi_nordy++;
                end
            end
            if (p_rv) chk("rsp_width", 64'(m_rv), 64'd0);
            if (m_rv) begin
                chk("rsp_csb_high", 64'(m_csb), 64'd1);
                chk("rsp_ready_low", 64'(m_ready), 64'd0);
                if (exp_q.size() == 0) fail_now("rsp_unexpected");
                else chk("rsp_data", 64'(m_data), 64'(exp_q.pop_front()));
                if (acc_q.size() == 0) fail_now("rsp_no_accept");
                else chk("rsp_latency", 64'(cyc - acc_q.pop_front()), 64'(1 + 127 * clkdiv_sel));
            end
        end
        p_csb = m_csb;
        p_sck = m_sck;
        p_io0 = m_io0;
        p_rv  = m_rv;
    end

    task automatic wait_ready(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (m_ready) break;
            @(negedge core_clk);
        end
        if (!m_ready) fail_now({name, "_ready_timeout"});
    endtask

    task automatic issue(input logic [23:0] a, input logic [31:0] exp, input bit track, input bit hold);
        if (sel) begin req_addr1 = a; req_valid1 = 1'b1; end
        else     begin req_addr0 = a; req_valid0 = 1'b1; end
        if (track) begin
            exp_q.push_back(exp);
            cmd_q.push_back(a);
        end
        wait_ready("issue");
        @(negedge core_clk);
        if (!hold) begin
            req_valid0 = 1'b0;
            req_valid1 = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge core_clk);
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        repeat (8) @(negedge core_clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn0 = 1'b0; rstn1 = 1'b0;
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        req_addr0 = '0; req_addr1 = '0;
        repeat (3) @(negedge core_clk);
        chk("rst_ready", 64'(ready0), 64'd0);
        chk("rst_rsp_valid", 64'(rv0), 64'd0);
        chk("rst_rsp_data", 64'(rd0), 64'd0);
        chk("rst_csb", 64'(csb0), 64'd1);
        chk("rst_sck", 64'(sck0), 64'd0);
        chk("rst_io0", 64'(io0_0), 64'd0);
        chk("io0_oeb", 64'(oeb0_0), 64'd0);
        chk("io1_oeb", 64'(oeb1_0), 64'd1);
        rstn0 = 1'b1;
        wait_ready("wake0");

        issue(24'h000010, 32'h0B00006F, 1'b1, 1'b0);
        drain();
        issue(24'h000123, 32'h26252423, 1'b1, 1'b0);
        issue(24'h00ABCD, 32'hD0CFCECD, 1'b1, 1'b1);
        issue(24'h12FFFE, 32'h1213EDEC, 1'b1, 1'b0);
        issue(24'hFFFFFE, 32'h01000001, 1'b1, 1'b0);
        drain();

        // Reset in the middle of a read, around the 40th SCK rising edge.
        issue(24'h000200, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            if (f_nrise >= 40) break;
            @(negedge core_clk);
        end
        if (f_nrise < 40) fail_now("sck40_timeout");
        #2 rstn0 = 1'b0;
        #1;
        chk("async_rst_csb", 64'(csb0), 64'd1);
        chk("async_rst_sck", 64'(sck0), 64'd0);
        chk("async_rst_rsp_valid", 64'(rv0), 64'd0);
        repeat (3) @(negedge core_clk);
        rstn0 = 1'b1;
        wait_ready("wake0_rerun");
        chk("wake_rerun", 64'(wake_windows), 64'd2);
        issue(24'h000010, 32'h0B00006F, 1'b1, 1'b0);
        drain();

        // Switch to the CLK_DIV=1 instance while both sides are quiet.
        sel = 1'b1;
        clkdiv_sel = 1;
        @(negedge core_clk);
        chk("rst1_csb", 64'(csb1), 64'd1);
        chk("rst1_ready", 64'(ready1), 64'd0);
        chk("rst1_rsp_data", 64'(rd1), 64'd0);
        rstn1 = 1'b1;
        wait_ready("wake1");
        issue(24'hFFFFFF, 32'h02010000, 1'b1, 1'b0);
        issue(24'h000010, 32'h0B00006F, 1'b1, 1'b0);
        drain();

        chk("queues_empty", 64'(exp_q.size() + cmd_q.size()), 64'd0);
        chk("wake_count", 64'(wake_windows), 64'd3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
